shift_iter_unit: RTL and testbench



---
 rtl/shift_pkg.sv | 32 +++
 rtl/shift_step.sv | 30 +++
 rtl/shift_iter_unit.sv | 94 +++++++++
 tb/tb_shift_iter_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Op codes, FSM state encoding and width defaults shared by the
//               iterative shifter and its one-bit step datapath.
// Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    localparam logic [2:0] SH_NOP = 3'b000;
    localparam logic [2:0] SH_SLL = 3'b001;
    localparam logic [2:0] SH_SRL = 3'b010;
    localparam logic [2:0] SH_SRA = 3'b011;
    localparam logic [2:0] SH_ROR = 3'b100;
    localparam logic [2:0] SH_ROL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codes 110/111 behave as NOP, so only the five real shifts need iterations.
    function automatic logic is_shift(input logic [2:0] op);
        return (op >= SH_SLL) && (op <= SH_ROL);
    endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational one-bit shift/rotate of a WIDTH-bit word.
// Revision    : 1.0  initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            SH_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
            SH_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
            SH_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            SH_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            SH_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            default: data_o = data_i;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_iter_unit
// Description : Multicycle shifter, one bit position per clock, with a
//               start/busy/done handshake for the control FSM.
// Revision    : 1.0  initial release
// ============================================================================
module shift_iter_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [SHAMT_W-1:0] cnt_q;
    logic [2:0]         op_q;
    logic               busy_q;
    logic               done_q;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i   (op_q),
        .data_i (acc_q),
        .data_o (acc_d)
    );

    // busy/done are registered alongside the state so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= SH_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q  <= data_in;
                        op_q   <= op;
                        cnt_q  <= shamt;
                        busy_q <= 1'b1;
                        if ((shamt != '0) && is_shift(op)) begin
                            state_q <= ST_SHIFT;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = acc_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : shift_iter_unit
`default_nettype wire

// File: tb/tb_shift_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_iter_unit
// Description : Self-checking bench for shift_iter_unit against an arithmetic
//               reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_iter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    shift_iter_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .data_in (data_in),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input int n, input logic [31:0] x);
        case (o)
            3'd1: return x << n;
            3'd2: return x >> n;
            3'd3: return 32'($signed(x) >>> n);
            3'd4: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
            3'd5: return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
            default: return x;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input int n);
        return (o >= 3'd1 && o <= 3'd5 && n != 0) ? n + 1 : 1;
    endfunction

    // Issues one start, then scrambles the inputs and observes until two
    // cycles past done (or a 40-cycle bound). lat==0 means done never came.
    task automatic do_txn(input logic [2:0] o, input logic [4:0] n, input logic [31:0] x,
                          output logic [31:0] res, output logic [31:0] res_held,
                          output int lat, output int busy_cnt, output int done_cnt);
        res = 'x; res_held = 'x; lat = 0; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        start = 1'b1; op = o; shamt = n; data_in = x;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat = i;
                    res = result;
                end
            end
            if (lat != 0 && i == lat + 2) begin
                res_held = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 3'd0; shamt = 5'd0; data_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]  ops  [7];
        logic [4:0]  ns   [7];
        logic [31:0] xs   [7];
        logic [31:0] exps [7];
        int          lats [7];
        logic [31:0] res, held;
        int lat, bc, dc;
        ops  = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd2, 3'd6};
        ns   = '{5'd4, 5'd31, 5'd31, 5'd1, 5'd4, 5'd0, 5'd7};
        xs   = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h00000001,
                 32'h80000001, 32'hDEADBEEF, 32'hDEADBEEF};
        exps = '{32'h00000010, 32'hFFFFFFFF, 32'h00000001, 32'h80000000,
                 32'h00000018, 32'hDEADBEEF, 32'hDEADBEEF};
        lats = '{5, 32, 32, 2, 5, 1, 1};
        for (int t = 0; t < 7; t++) begin
            do_txn(ops[t], ns[t], xs[t], res, held, lat, bc, dc);
            tests++; if (res !== exps[t]) begin fails++; $display("FAIL dir%0d_result got=%h exp=%h", t, res, exps[t]); end
            tests++; if (lat != lats[t])  begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", t, lat, lats[t]); end
            tests++; if (bc != lats[t])   begin fails++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", t, bc, lats[t]); end
            tests++; if (dc != 1)         begin fails++; $display("FAIL dir%0d_done_pulses got=%0d exp=1", t, dc); end
            tests++; if (held !== exps[t]) begin fails++; $display("FAIL dir%0d_result_held got=%h exp=%h", t, held, exps[t]); end
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [4:0]  n;
        logic [31:0] x, res, held, exp_r;
        int lat, bc, dc, exp_l;
        for (int t = 0; t < 24; t++) begin
            o = 3'($urandom_range(0, 7));
            n = 5'($urandom_range(0, 31));
            x = $urandom;
            exp_r = model(o, int'(n), x);
            exp_l = model_lat(o, int'(n));
            do_txn(o, n, x, res, held, lat, bc, dc);
            tests++; if (res !== exp_r) begin fails++; $display("FAIL rnd%0d_result op=%0d n=%0d x=%h got=%h exp=%h", t, o, n, x, res, exp_r); end
            tests++; if (lat != exp_l)  begin fails++; $display("FAIL rnd%0d_latency op=%0d n=%0d got=%0d exp=%0d", t, o, n, lat, exp_l); end
            tests++; if (bc != exp_l)   begin fails++; $display("FAIL rnd%0d_busy_cycles got=%0d exp=%0d", t, bc, exp_l); end
            tests++; if (dc != 1)       begin fails++; $display("FAIL rnd%0d_done_pulses got=%0d exp=1", t, dc); end
        end
    endtask

    task automatic test_busy_start;
        int lat, dc;
        logic [31:0] res;
        lat = 0; dc = 0; res = 'x;
        @(negedge clk);
        start = 1'b1; op = 3'd1; shamt = 5'd8; data_in = 32'h1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                if (lat == 0) begin lat = i; res = result; end
            end
            if (i == 3) begin
                start = 1'b1; op = 3'd2; shamt = 5'd4; data_in = 32'hFFFF0000;
            end else begin
                start = 1'b0;
            end
        end
        tests++; if (res !== 32'h100) begin fails++; $display("FAIL busy_start_result got=%h exp=%h", res, 32'h100); end
        tests++; if (lat != 9)        begin fails++; $display("FAIL busy_start_latency got=%0d exp=9", lat); end
        tests++; if (dc != 1)         begin fails++; $display("FAIL busy_start_done_pulses got=%0d exp=1", dc); end
    endtask

    task automatic test_back_to_back;
        logic exp_d;
        // start held high: each SLL-by-2 occupies 4 cycles, so done recurs every 4.
        @(negedge clk);
        start = 1'b1; op = 3'd1; shamt = 5'd2; data_in = 32'h1;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_d = (i % 4 == 3);
            tests++; if (done !== exp_d) begin fails++; $display("FAIL b2b_done_c%0d got=%b exp=%b", i, done, exp_d); end
            if (exp_d) begin
                tests++; if (result !== 32'h4) begin fails++; $display("FAIL b2b_result_c%0d got=%h exp=%h", i, result, 32'h4); end
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dc;
        logic [31:0] res, held;
        int lat, bc, dcc;
        @(negedge clk);
        start = 1'b1; op = 3'd1; shamt = 5'd10; data_in = 32'h1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL rstmid_result got=%h exp=%h", result, 32'h0); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL rstmid_done got=%b exp=0", done); end
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        tests++; if (dc != 0) begin fails++; $display("FAIL rstmid_activity_after got=%0d exp=0", dc); end

        reset = 1'b1; start = 1'b1; op = 3'd0; shamt = 5'd0; data_in = 32'hDEADBEEF;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        dc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy || result != 32'h0) dc++;
        end
        tests++; if (dc != 0) begin fails++; $display("FAIL rst_and_start_activity got=%0d exp=0", dc); end

        do_txn(3'd1, 5'd5, 32'h3, res, held, lat, bc, dcc);
        tests++; if (res !== 32'h60) begin fails++; $display("FAIL rst_fresh_result got=%h exp=%h", res, 32'h60); end
        tests++; if (lat != 6)       begin fails++; $display("FAIL rst_fresh_latency got=%0d exp=6", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_iter_unit
`default_nettype wire
